xmem_regbank: RTL

Parametrised AVR external-memory (XMEM) register bank for the I/O FPGA. It decodes a configurable 256-byte page of the AVR address space and exposes N_MOT motor control/velocity registers, N_SRV 10-bit servo positions with atomic commit, and N_ENC 16-bit encoder counters with tear-free reads and clear strobes. All bus strobes are synchronised into `clk`, and a small bus FSM guarantees exactly one register action per strobe.

---
 rtl/xmem_regbank_if.sv | 19 +
 rtl/xmem_regbank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/xmem_regbank_if.sv
// -----------------------------------------------------------------------------
// xmem_regbank_if
// AVR XMEM control-side bus seen by the register bank.
//   a    [7:0]  address high byte (page select)
//   ale         address latch enable, active-high
//   nRD         read strobe, active-low (asynchronous to clk)
//   nWR         write strobe, active-low (asynchronous to clk)
// The multiplexed ad[7:0] bus is bidirectional and stays a plain inout port
// on the register bank so the tristate resolves at the pin.
// -----------------------------------------------------------------------------
interface xmem_regbank_if;
    logic [7:0] a;
    logic       ale;
    logic       nRD;
    logic       nWR;

    modport master (output a, ale, nRD, nWR);
    modport slave  (input  a, ale, nRD, nWR);
endinterface

// File: rtl/xmem_regbank.sv
// -----------------------------------------------------------------------------
// xmem_regbank
// AVR external-memory register bank for the I/O FPGA. Decodes the 256-byte
// page selected by a == BASE and provides motor control/velocity registers,
// 10-bit servo positions, tear-free 16-bit encoder reads with clear strobes,
// synchronised digital inputs and version/configuration readback.
//
// Ports
//   clk, nRST        system clock, asynchronous active-low reset
//   bus              a / ale / nRD / nWR (xmem_regbank_if.slave)
//   ad      [7:0]    multiplexed address-low / data bus (inout)
//   aout    [7:0]    latched address low byte to SRAM
//   ramce            SRAM chip enable (~a[7])
//   mot_ctl          motor i control  at [2i+1:2i]
//   mot_vel          motor i velocity at [8i+7:8i]
//   srv_pos          servo i position at [10i+9:10i]
//   enc_cnt          encoder i count  at [16i+15:16i]
//   enc_clr          one-clk clear pulse per encoder
//   digital [7:0]    asynchronous digital inputs
//
// Build option
//   XMEM_SRV_ATOMIC_EN  defined: servo low byte goes to a staging register and
//                       the high-byte write commits all 10 bits at once.
//                       undefined: low/high servo bytes write straight through.
// -----------------------------------------------------------------------------
module xmem_regbank #(
    parameter int unsigned N_MOT = 6,
    parameter int unsigned N_SRV = 6,
    parameter int unsigned N_ENC = 4,
    parameter logic [7:0]  BASE  = 8'h11,
    parameter logic [7:0]  MAJOR = 8'd1,
    parameter logic [7:0]  MINOR = 8'd0
) (
    input  logic                clk,
    input  logic                nRST,
    xmem_regbank_if.slave       bus,
    inout  logic [7:0]          ad,
    output logic [7:0]          aout,
    output logic                ramce,
    output logic [2*N_MOT-1:0]  mot_ctl,
    output logic [8*N_MOT-1:0]  mot_vel,
    output logic [10*N_SRV-1:0] srv_pos,
    input  logic [16*N_ENC-1:0] enc_cnt,
    output logic [N_ENC-1:0]    enc_clr,
    input  logic [7:0]          digital
);

    typedef enum logic [1:0] {SYNCWAIT, IDLE, WR_ACT, RD_ACT} state_e;

    state_e           state_q, state_d;
    logic             do_wr, do_rd;

    logic [1:0]       nrd_sync_q, nwr_sync_q;
    logic [7:0]       dig_meta_q, dig_q;
    logic [7:0]       addr_lo_q;
    logic [7:0]       rd_q, rd_d;

    logic [1:0]       ctl_q    [N_MOT];
    logic [1:0]       ctl_d    [N_MOT];
    logic [7:0]       vel_q    [N_MOT];
    logic [7:0]       vel_d    [N_MOT];
    logic [9:0]       srv_q    [N_SRV];
    logic [9:0]       srv_d    [N_SRV];
`ifdef XMEM_SRV_ATOMIC_EN
    logic [7:0]       stg_q    [N_SRV];
    logic [7:0]       stg_d    [N_SRV];
`endif
    logic [7:0]       shadow_q [N_ENC];
    logic [7:0]       shadow_d [N_ENC];
    logic [N_ENC-1:0] clr_q, clr_d;

    logic             nrd_s, nwr_s, hit, odd;
    logic [2:0]       region;
    logic [3:0]       idx;

    assign nrd_s  = nrd_sync_q[1];
    assign nwr_s  = nwr_sync_q[1];
    assign hit    = (bus.a == BASE);
    assign region = addr_lo_q[7:5];
    assign idx    = addr_lo_q[4:1];
    assign odd    = addr_lo_q[0];

    assign aout    = bus.ale ? ad : addr_lo_q;
    assign ramce   = ~bus.a[7];
    assign enc_clr = clr_q;

    // Drive on the raw strobe so the AVR sees data as early as possible;
    // rd_q itself only changes on the synchronised read-execute edge.
    assign ad = (!bus.nRD && hit) ? rd_q : 'z;

    // ---------------------------------------------------------------- bus FSM
    // Synchronisers reset to the asserted level so a strobe already low when
    // reset is released is held off in SYNCWAIT until it really deasserts.
    always_comb begin
        state_d = state_q;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        case (state_q)
            SYNCWAIT: if (nrd_s && nwr_s) state_d = IDLE;
            IDLE: begin
                if (!nwr_s) begin
                    state_d = WR_ACT;
                    do_wr   = 1'b1;
                end else if (!nrd_s) begin
                    state_d = RD_ACT;
                    do_rd   = 1'b1;
                end
            end
            WR_ACT:   if (nwr_s) state_d = IDLE;
            RD_ACT:   if (nrd_s) state_d = IDLE;
            default:  state_d = SYNCWAIT;
        endcase
    end

    // ------------------------------------------------------- register actions
    always_comb begin
        ctl_d    = ctl_q;
        vel_d    = vel_q;
        srv_d    = srv_q;
`ifdef XMEM_SRV_ATOMIC_EN
        stg_d    = stg_q;
`endif
        shadow_d = shadow_q;
        clr_d    = '0;
        rd_d     = rd_q;

        if (do_wr && hit) begin
            case (region)
                3'd0: for (int unsigned i = 0; i < N_MOT; i++) begin
                    if (idx == i[3:0]) begin
                        if (odd) vel_d[i] = ad;
                        else     ctl_d[i] = ad[1:0];
                    end
                end
                3'd1: for (int unsigned i = 0; i < N_SRV; i++) begin
                    if (idx == i[3:0]) begin
`ifdef XMEM_SRV_ATOMIC_EN
                        if (odd) srv_d[i] = {ad[1:0], stg_q[i]};
                        else     stg_d[i] = ad;
`else
                        if (odd) srv_d[i][9:8] = ad[1:0];
                        else     srv_d[i][7:0] = ad;
`endif
                    end
                end
                3'd2: for (int unsigned i = 0; i < N_ENC; i++) begin
                    if (idx == i[3:0] && !odd) clr_d[i] = 1'b1;
                end
                default: ;
            endcase
        end

        if (do_rd && hit) begin
            rd_d = '0;
            case (region)
                3'd0: for (int unsigned i = 0; i < N_MOT; i++) begin
                    if (idx == i[3:0]) rd_d = odd ? vel_q[i] : {6'd0, ctl_q[i]};
                end
                3'd2: for (int unsigned i = 0; i < N_ENC; i++) begin
                    if (idx == i[3:0]) begin
                        // Low-byte read freezes the high byte so the
                        // following high-byte read matches this sample.
                        if (odd) begin
                            rd_d = shadow_q[i];
                        end else begin
                            rd_d        = enc_cnt[16*i +: 8];
                            shadow_d[i] = enc_cnt[16*i+8 +: 8];
                        end
                    end
                end
                default: begin
                    case (addr_lo_q)
                        8'h60:   rd_d = dig_q;
                        8'h61:   rd_d = 8'(N_MOT);
                        8'h62:   rd_d = 8'(N_SRV);
                        8'h63:   rd_d = 8'(N_ENC);
                        8'hFE:   rd_d = MAJOR;
                        8'hFF:   rd_d = MINOR;
                        default: rd_d = '0;
                    endcase
                end
            endcase
        end
    end

    // --------------------------------------------------------------- state
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= SYNCWAIT;
            nrd_sync_q <= '0;
            nwr_sync_q <= '0;
            dig_meta_q <= '0;
            dig_q      <= '0;
            addr_lo_q  <= '0;
            rd_q       <= '0;
            ctl_q      <= '{default: '0};
            vel_q      <= '{default: '0};
            srv_q      <= '{default: '0};
`ifdef XMEM_SRV_ATOMIC_EN
            stg_q      <= '{default: '0};
`endif
            shadow_q   <= '{default: '0};
            clr_q      <= '0;
        end else begin
            state_q    <= state_d;
            nrd_sync_q <= {nrd_sync_q[0], bus.nRD};
            nwr_sync_q <= {nwr_sync_q[0], bus.nWR};
            dig_meta_q <= digital;
            dig_q      <= dig_meta_q;
            if (bus.ale) addr_lo_q <= ad;
            rd_q       <= rd_d;
            ctl_q      <= ctl_d;
            vel_q      <= vel_d;
            srv_q      <= srv_d;
`ifdef XMEM_SRV_ATOMIC_EN
            stg_q      <= stg_d;
`endif
            shadow_q   <= shadow_d;
            clr_q      <= clr_d;
        end
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        mot_ctl = '0;
        mot_vel = '0;
        srv_pos = '0;
        for (int unsigned i = 0; i < N_MOT; i++) begin
            mot_ctl[2*i +: 2] = ctl_q[i];
            mot_vel[8*i +: 8] = vel_q[i];
        end
        for (int unsigned i = 0; i < N_SRV; i++) begin
            srv_pos[10*i +: 10] = srv_q[i];
        end
    end

endmodule
